axi4lite_resp_regfile: RTL
==========================

AXI4LITE_RESP_REGFILE -- requirements
Module: axi4lite_resp_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, byte-address width of AWADDR/ARADDR; one register per address.
REQ-002 Parameter DATA_WIDTH, default 8, width of every register and of WDATA/RDATA.
REQ-003 Parameter NUM_REGS, default 4, number of implemented registers, range 1..2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_awaddr  input  ADDR_WIDTH  write address.
REQ-007 s_awvalid  input  1 / s_awready  output  1  write-address handshake.
REQ-008 s_wdata  input  DATA_WIDTH  write data.
REQ-009 s_wvalid  input  1 / s_wready  output  1  write-data handshake.
REQ-010 s_bresp  output  2 / s_bvalid  output  1 / s_bready  input  1  write response channel.
REQ-011 s_araddr  input  ADDR_WIDTH / s_arvalid  input  1 / s_arready  output  1  read-address channel.
REQ-012 s_rdata  output  DATA_WIDTH / s_rresp  output  2 / s_rvalid  output  1 / s_rready  input  1  read-data channel.
REQ-013 regs_flat  output  NUM_REGS*DATA_WIDTH  live register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-014 Handshake on any channel SHALL occur on a rising edge where VALID and READY are both 1.
REQ-015 Write side SHALL hold two flags aw_held, w_held plus address/data buffers; states: IDLE (neither), HAVE_ADDR, HAVE_DATA, RESP (bvalid=1).
REQ-016 s_awready SHALL equal !aw_held && !s_bvalid; s_wready SHALL equal !w_held && !s_bvalid (combinational from registered state).
REQ-017 AW and W SHALL be accepted in either order or in the same cycle; the earlier one is buffered until its partner arrives.
REQ-018 At the edge where both address and data are available (held or handshaking that edge), the block SHALL commit the write, clear both flags and set s_bvalid=1 on that same edge.
REQ-019 Commit with address < NUM_REGS SHALL update that register and set s_bresp=2'b00 (OKAY); address >= NUM_REGS SHALL leave all registers unchanged and set s_bresp=2'b10 (SLVERR).
REQ-020 s_bvalid and s_bresp SHALL stay stable until the s_bready handshake; s_bvalid clears on that edge, readies return the following cycle.
REQ-021 s_arready SHALL equal !s_rvalid.
REQ-022 On AR handshake the block SHALL register s_rdata = register[s_araddr] (value before any write committing the same edge), s_rresp=2'b00, s_rvalid=1; address >= NUM_REGS gives s_rdata=0, s_rresp=2'b10.
REQ-023 Read latency SHALL be exactly one cycle from AR handshake to s_rvalid=1; s_rdata/s_rresp stable until the R handshake, which clears s_rvalid.
REQ-024 Read and write paths SHALL be independent; simultaneous read and write to one register SHALL return the old value, the new value visible to later reads.
REQ-025 Peak throughput: one write per two cycles, one read per two cycles; no transaction SHALL be dropped or duplicated under arbitrary VALID/READY stalls.
REQ-026 Address bits SHALL be used as-is (no alignment shift); no wrap-around beyond NUM_REGS, handled by REQ-019/REQ-022.

Reset
REQ-027 While rst=1, all registers, regs_flat, s_bvalid, s_rvalid, s_rdata, s_bresp, s_rresp, aw_held, w_held SHALL be 0 immediately (asynchronously); s_awready, s_wready, s_arready SHALL read 1 from reset release.
REQ-028 Reset mid-transaction SHALL discard buffered address/data and any pending response; no register update from a partially received write.

Verification
REQ-029 AW=2, W=0x04 same cycle, bready=1 -> bvalid one edge later with bresp=00, regs_flat[23:16]=0x04; then AR=2 -> rvalid next cycle, rdata=0x04, rresp=00.
REQ-030 W=0xA5 three cycles before AW=1 -> wready low after W accepted, no update until AW; then reg1=0xA5, exactly one bvalid pulse.
REQ-031 NUM_REGS=3, write 0x5A to addr 3 and read addr 3 -> bresp=10, rresp=10, rdata=0x00, regs_flat unchanged.
REQ-032 bready held 0 for 5 cycles after a write -> bvalid/bresp stable, awready=wready=0 throughout; second write accepted only after B handshake.
REQ-033 Write 0x33 and read same address on same edge with reg holding 0x11 -> rdata=0x11; subsequent read returns 0x33.
REQ-034 Assert rst while AW held and rvalid=1 -> rvalid, bvalid, all registers 0 immediately; after release a W alone produces no bvalid.

Source files
------------

// File: rtl/axi4lite_resp_regfile.sv
// axi4lite_resp_regfile: AXI4-Lite register file with OKAY/SLVERR responses and independent read/write paths.
module axi4lite_resp_regfile #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);
  logic                  aw_held, w_held, aw_hs, w_hs, commit, wr_ok, rd_ok;
  logic [ADDR_WIDTH-1:0] aw_buf, waddr;
  logic [DATA_WIDTH-1:0] w_buf, wdata, rd_val;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  assign s_awready = !aw_held && !s_bvalid;
  assign s_wready  = !w_held && !s_bvalid;
  assign s_arready = !s_rvalid;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  // a buffered half always takes precedence over the live bus value
  assign waddr     = aw_held ? aw_buf : s_awaddr;
  assign wdata     = w_held ? w_buf : s_wdata;
  assign commit    = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_ok     = 32'(waddr) < NUM_REGS;
  assign rd_ok     = 32'(s_araddr) < NUM_REGS;
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (s_araddr == ADDR_WIDTH'(i)) rd_val = regs[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (waddr == ADDR_WIDTH'(i)) regs[i] <= wdata;
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_buf   <= '0;
      w_buf    <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= 2'b00;
    end else begin
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= wr_ok ? 2'b00 : 2'b10;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_buf  <= s_awaddr;
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_buf  <= s_wdata;
        end
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
    end
  end
  // regs are sampled before this edge's write lands, so same-edge reads see the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= 2'b00;
    end else if (s_arvalid && s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_ok ? rd_val : '0;
      s_rresp  <= rd_ok ? 2'b00 : 2'b10;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end
endmodule
